jt6295_serial_mc: RTL

JT6295_SERIAL_MC -- requirements
Module: jt6295_serial_mc

---
 rtl/jt6295_pkg.sv | 25 ++
 rtl/jt6295_ch_ring.sv | 37 +++
 rtl/jt6295_serial_mc.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/jt6295_pkg.sv
// jt6295_pkg: shared constants for the serial multichannel sample fetcher.
// Default sizes, nibble order and the ring slot-index helper.
package jt6295_pkg;

  localparam int CH_DEF = 4;
  localparam int AW_DEF = 18;

  typedef enum logic {
    NIB_HI = 1'b0,
    NIB_LO = 1'b1
  } nib_e;

  // Counter LSB value that selects the high nibble (played first).
  localparam nib_e FIRST_NIB = NIB_HI;

  // Ring stage holding channel ch while slot s sits at the head.
  function automatic int unsigned slot_idx(
    input int unsigned ch,
    input int unsigned s,
    input int unsigned n
  );
    return (ch + n - s) % n;
  endfunction

endpackage

// File: rtl/jt6295_ch_ring.sv
// jt6295_ch_ring: circular register ring holding per-channel state.
// Stage 0 is the channel of the current slot; it re-enters at the tail.
module jt6295_ch_ring
  import jt6295_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int W  = 8
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen_i,
  input  logic [W-1:0]         tail_i,
  output logic [CH-1:0][W-1:0] stage_o
);

  logic [CH-1:0][W-1:0] ring_q, ring_d;

  // Rotate one stage per slot strobe; updated head enters at the tail.
  always_comb begin
    ring_d = ring_q;
    if (cen_i) begin
      for (int i = 0; i < CH - 1; i++) begin
        ring_d[i] = ring_q[i+1];
      end
      ring_d[CH-1] = tail_i;
    end
  end

  // Ring storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) ring_q <= '0;
    else        ring_q <= ring_d;
  end

  assign stage_o = ring_q;

endmodule

// File: rtl/jt6295_serial_mc.sv
// jt6295_serial_mc: time-multiplexed sample address generator.
// One channel is serviced per slot strobe; output is a nibble stream.
module jt6295_serial_mc
  import jt6295_pkg::*;
#(
  parameter int CH  = CH_DEF,
  parameter int AW  = AW_DEF,
  parameter int CHW = $clog2(CH)
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen_slot,
  input  logic [AW-1:0]  start_addr,
  input  logic [AW-1:0]  stop_addr,
  input  logic [3:0]     att,
  input  logic           loop_en,
  input  logic [CH-1:0]  start,
  input  logic [CH-1:0]  stop,
  output logic [CH-1:0]  busy,
  output logic [CH-1:0]  ack,
  output logic [CH-1:0]  done,
  output logic           frame,
  output logic [AW-1:0]  rom_addr,
  input  logic [7:0]     rom_data,
  output logic           pipe_en,
  output logic [CHW-1:0] pipe_ch,
  output logic [3:0]     pipe_att,
  output logic [3:0]     pipe_data
);

  localparam int W = 3*AW + 7;

  logic [CH-1:0][W-1:0] st;
  logic [W-1:0]         tail;

  logic [AW:0]    h_cnt, n_cnt;
  logic [AW-1:0]  h_stop, n_stop;
  logic [AW-1:0]  h_ls, n_ls;
  logic [3:0]     h_att, n_att;
  logic           h_loop, n_loop;
  logic           h_busy, n_busy;

  logic [CHW-1:0] slot_q, slot_d;
  logic [CH-1:0]  ack_q, ack_d;
  logic [CH-1:0]  done_q, done_d;
  logic           pen_q;
  logic [CHW-1:0] pch_q;
  logic [3:0]     patt_q, pdat_q, nib;
  logic [CHW-1:0] idx;
  logic           at_end;

  jt6295_ch_ring #(
    .CH (CH),
    .W  (W)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen_i   (cen_slot),
    .tail_i  (tail),
    .stage_o (st)
  );

  assign {h_cnt, h_stop, h_ls, h_att, h_loop, h_busy} = st[0];
  assign tail = {n_cnt, n_stop, n_ls, n_att, n_loop, n_busy};

  assign rom_addr = h_cnt[AW:1];
  assign frame    = (slot_q == '0);

  // The last nibble of the stop byte is still played before ending.
  assign at_end = (h_cnt >= {h_stop, 1'b1});

  assign slot_d = (slot_q == CHW'(CH - 1)) ? '0 : slot_q + CHW'(1);

  assign nib = (nib_e'(h_cnt[0]) == FIRST_NIB) ? rom_data[7:4]
                                               : rom_data[3:0];

  // Next state of the channel at the head of the ring.
  always_comb begin
    n_cnt  = h_cnt;
    n_stop = h_stop;
    n_ls   = h_ls;
    n_att  = h_att;
    n_loop = h_loop;
    n_busy = h_busy;
    ack_d  = '0;
    done_d = '0;
    if (start[slot_q]) begin
      n_cnt         = {start_addr, 1'b0};
      n_stop        = stop_addr;
      n_ls          = start_addr;
      n_att         = att;
      n_loop        = loop_en;
      n_busy        = !stop[slot_q];
      ack_d[slot_q] = 1'b1;
    end else if (stop[slot_q]) begin
      n_busy = 1'b0;
    end else if (h_busy) begin
      if (!at_end) begin
        n_cnt = h_cnt + {{AW{1'b0}}, 1'b1};
      end else if (h_loop) begin
        n_cnt = {h_ls, 1'b0};
      end else begin
        n_busy         = 1'b0;
        done_d[slot_q] = 1'b1;
      end
    end
  end

  // Un-rotate the ring to present busy by channel number.
  always_comb begin
    busy = '0;
    idx  = '0;
    for (int c = 0; c < CH; c++) begin
      idx     = CHW'(slot_idx(c, 32'(slot_q), CH));
      busy[c] = st[idx][0];
    end
  end

  // Slot pointer, handshake pulses and nibble output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
      ack_q  <= '0;
      done_q <= '0;
      pen_q  <= 1'b0;
      pch_q  <= '0;
      patt_q <= '0;
      pdat_q <= '0;
    end else if (cen_slot) begin
      slot_q <= slot_d;
      ack_q  <= ack_d;
      done_q <= done_d;
      pen_q  <= h_busy;
      pch_q  <= slot_q;
      patt_q <= h_att;
      pdat_q <= nib;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign pipe_en   = pen_q;
  assign pipe_ch   = pch_q;
  assign pipe_att  = patt_q;
  assign pipe_data = pdat_q;

endmodule
